// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH runtime-reprogrammable clock dividers with a settle indicator.
// Optional macro CLKDIV_PHASE_ALIGN_EN: any apply restarts every channel counter on the same edge.
module clk_div_bank #(
  parameter int                      NUM_CH     = 2,
  parameter int                      CNT_W      = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV    = {8'd4, 8'd2},
  parameter int                      SETTLE_CYC = 16,
  localparam int                     CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLKIN,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_rdy,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_div,
  output logic [NUM_CH-1:0] ce,
  output logic              clks_valid
);
  localparam int ST_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic {SETTLE = 1'b0, LOCKED = 1'b1} settle_t;

  logic [CNT_W-1:0]  r_cnt    [NUM_CH];
  logic [CNT_W-1:0]  r_div    [NUM_CH];
  logic [CNT_W-1:0]  r_shadow [NUM_CH];
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_ce;
  logic              r_rdy;
  logic              r_err;
  logic              r_valid;
  logic              r_run;
  settle_t           r_state;
  logic [ST_W-1:0]   r_settle;

  logic [CNT_W-1:0]  w_cnt_nx [NUM_CH];
  logic [CNT_W-1:0]  w_div_nx [NUM_CH];
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_pend_nx;
  logic              w_apply_any;
  logic              w_accept;
  logic              w_bad;
  logic              w_good;

  // Next-state for counters, divisors and pending flags; r_run holds cnt at 0 on the release edge.
  always_comb begin
    w_accept = cfg_wr & r_rdy;
    w_bad    = (cfg_div < CNT_W'(2)) || (int'(cfg_ch) >= NUM_CH);
    w_good   = w_accept & ~w_bad;
    for (int i = 0; i < NUM_CH; i++) begin
      w_apply[i] = r_pend[i] && (r_cnt[i] == (r_div[i] - CNT_W'(1)));
    end
    w_apply_any = |w_apply;
    for (int i = 0; i < NUM_CH; i++) begin
      w_div_nx[i]  = w_apply[i] ? r_shadow[i] : r_div[i];
      w_pend_nx[i] = (r_pend[i] & ~w_apply[i]) | (w_good && (int'(cfg_ch) == i));
      if (!r_run || (r_cnt[i] == (r_div[i] - CNT_W'(1)))) begin
        w_cnt_nx[i] = '0;
`ifdef CLKDIV_PHASE_ALIGN_EN
      end else if (w_apply_any) begin
        w_cnt_nx[i] = '0;
`endif
      end else begin
        w_cnt_nx[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  // Channel state and outputs; outputs are computed from the next cnt so they align with it.
  always_ff @(posedge CLKIN) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i]    <= '0;
        r_div[i]    <= DEF_DIV[i*CNT_W +: CNT_W];
        r_shadow[i] <= '0;
      end
      r_pend <= '0;
      r_clk  <= '0;
      r_ce   <= '0;
      r_rdy  <= 1'b0;
      r_err  <= 1'b0;
      r_run  <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_rdy  <= ~|w_pend_nx;
      r_err  <= w_accept & w_bad;
      r_pend <= w_pend_nx;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= w_cnt_nx[i];
        r_div[i] <= w_div_nx[i];
        if (w_good && (int'(cfg_ch) == i)) begin
          r_shadow[i] <= cfg_div;
        end
        r_clk[i] <= (w_cnt_nx[i] >= (w_div_nx[i] >> 1));
        r_ce[i]  <= (w_cnt_nx[i] == (w_div_nx[i] - CNT_W'(1)));
      end
    end
  end

  // Settle tracker: counts quiet cycles from release or apply edge, then locks.
  always_ff @(posedge CLKIN) begin
    if (!rst_n || !r_run) begin
      r_state  <= SETTLE;
      r_settle <= '0;
      r_valid  <= 1'b0;
    end else if (w_good) begin
      r_state  <= SETTLE;
      r_settle <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        SETTLE: begin
          r_valid <= 1'b0;
          if ((r_pend != '0) && !w_apply_any) begin
            r_settle <= '0;
          end else if (r_settle == ST_W'(SETTLE_CYC - 1)) begin
            r_state <= LOCKED;
            r_valid <= 1'b1;
          end else begin
            r_settle <= r_settle + ST_W'(1);
          end
        end
        LOCKED: begin
          r_valid <= 1'b1;
        end
        default: begin
          r_state  <= SETTLE;
          r_settle <= '0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_rdy    = r_rdy;
  assign cfg_err    = r_err;
  assign clk_div    = r_clk;
  assign ce         = r_ce;
  assign clks_valid = r_valid;
endmodule
